ad9910_spi_responder: RTL and testbench
=======================================

// Module: ad9910_spi_responder
// PURPOSE
//  Synthesizable model of the AD9910 serial port and register file: the slave end of the DDS SPI link.
//  Decodes 3-wire SPI frames (instruction + data) into a shadow I/O buffer and copies it to active
//  registers on io_update. Drives sdio on read frames. Sits in loopback benches/FPGA self-test against
//  the DDS driver, exposing active registers for checking.
// PARAMETERS
//  CS_ACTIVE_LOW  1  1: frame while cs==0; 0: frame while cs==1
//  SYNC_STAGES    2  flip-flop synchronizer depth on sck/cs/sdio_in/io_update (>=2)
// PORTS
//  clk              in   1   system clock; all logic on posedge
//  reset            in   1   synchronous, active-high
//  sck              in   1   SPI clock, CPOL=0/CPHA=0, MSB first
//  cs               in   1   chip select, polarity per CS_ACTIVE_LOW
//  sdio_in          in   1   sampled sdio line
//  sdio_out         out  1   read data bit
//  sdio_oe          out  1   1 = responder drives sdio
//  io_update        in   1   rising edge transfers shadow -> active
//  profile          in   3   selects active profile register 0x0E+profile
//  cfr1_q/cfr2_q/cfr3_q  out 32 active CFR1..CFR3
//  ftw_q            out  32  active FTW (0x07)
//  profile_word_q   out  64  active profile register selected by profile
//  frame_count      out  16  completed (cs-released, non-aborted) frames, wraps
//  update_count     out  16  io_update rising edges seen, wraps
//  frame_error      out  1   sticky: frame aborted mid-byte/mid-data or bad address; cleared by reset only
// BEHAVIOUR
//  - Inputs pass SYNC_STAGES FFs, then 1-FF edge detect; sck high/low each >= SYNC_STAGES+2 clk.
//  - Register lengths: 0x00-0x04,0x07,0x09,0x0A,0x0D,0x16 = 32b; 0x08 = 16b; 0x0B,0x0C,0x0E-0x15 = 64b.
//    0x05,0x06,0x17-0x1F invalid: 32b length, writes discarded, reads return 0, frame_error set.
//  - Reset values: all shadow/active regs 0 except CFR1=0, CFR2=0x0040_0820, CFR3=0x1F3F_4000;
//    sdio_oe=0, sdio_out=0, counters 0, frame_error=0, FSM IDLE.
//  - FSM: IDLE -(cs active)-> INSTR; INSTR shifts 8 bits on sck rise; bit7=1 read, [4:0] address.
//    After 8th bit: write -> WDATA, read -> RDATA. WDATA shifts len bits; on last bit the shadow reg is
//    written (next clk) and FSM -> DONE. RDATA: load active reg into shift reg, sdio_oe=1 and
//    sdio_out=MSB one clk after 8th instr rise; next bit on each sck fall; after len bits -> DONE.
//    DONE ignores further sck. Any state -(cs inactive)-> IDLE, sdio_oe=0 same clk.
//  - cs release in INSTR(>0 bits)/WDATA/RDATA before len bits = abort: no shadow write, frame_error=1,
//    frame_count unchanged. cs release in DONE: frame_count+1. cs release in INSTR with 0 bits: no-op.
//  - Reads return active (not shadow) values.
//  - io_update rise: all shadow -> active in one clk, update_count+1. Same clk as a shadow write
//    completion: the new write is included in the transfer.
//  - profile_word_q combinational mux of active regs on synchronized profile (latency SYNC_STAGES).
//  - reset mid-frame: FSM IDLE, frame discarded, no error flagged; a frame in progress at reset
//    release is ignored until cs goes inactive then active again.
// TESTING
//  1 write 0x07 FTW 0x1234_5678, no io_update -> ftw_q=0; pulse io_update -> ftw_q=0x1234_5678, update_count=1.
//  2 write 0x0E = 0x3FFF_0000_1999_999A, profile=0 -> profile_word_q=that value after update;
//    profile=1 -> profile_word_q=0.
//  3 read 0x01 after reset -> 32 sdio bits = 0x0040_0820, sdio_oe high only in data phase.
//  4 write 0x08 with cs released after 10 data bits -> frame_error=1, frame_count unchanged, POW not written.
//  5 write 0x00 = 0x0000_0002 completing same clk as io_update rise -> cfr1_q=0x0000_0002 next clk.
//  6 reset asserted during 64-bit write to 0x0B -> regs at defaults; next full frame completes normally.

Source files
------------

// File: rtl/ad9910_spi_responder_if.sv
// SPI link and control signals between an AD9910 driver (master) and the
// responder model (slave).
interface ad9910_spi_responder_if;
    logic       sck;
    logic       cs;
    logic       sdio_in;
    logic       sdio_out;
    logic       sdio_oe;
    logic       io_update;
    logic [2:0] profile;

    modport master (
        output sck, cs, sdio_in, io_update, profile,
        input  sdio_out, sdio_oe
    );

    modport slave (
        input  sck, cs, sdio_in, io_update, profile,
        output sdio_out, sdio_oe
    );
endinterface

// File: rtl/ad9910_spi_responder.sv
// AD9910 serial port and register file model: decodes 3-wire SPI frames into a
// shadow buffer, copies it to active registers on io_update, serves reads.
module ad9910_spi_responder #(
    parameter bit          CS_ACTIVE_LOW = 1'b1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    ad9910_spi_responder_if.slave   spi,
    output logic [31:0]             cfr1_q,
    output logic [31:0]             cfr2_q,
    output logic [31:0]             cfr3_q,
    output logic [31:0]             ftw_q,
    output logic [63:0]             profile_word_q,
    output logic [15:0]             frame_count,
    output logic [15:0]             update_count,
    output logic                    frame_error
);
    typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

    // Synchronizer lanes: {profile[2:0], io_update, sdio_in, cs, sck}
    logic [6:0]  sync_q [SYNC_STAGES];
    logic [6:0]  sync_d [SYNC_STAGES];
    logic        sck_prev_q, sck_prev_d, upd_prev_q, upd_prev_d;
    state_t      state_q, state_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [63:0] shift_q, shift_d;
    logic [4:0]  addr_q, addr_d;
    logic        armed_q, armed_d;
    logic        sdio_out_q, sdio_out_d, sdio_oe_q, sdio_oe_d;
    logic [15:0] frame_count_q, frame_count_d, update_count_q, update_count_d;
    logic        frame_error_q, frame_error_d;
    logic [63:0] shadow_q [32];
    logic [63:0] shadow_d [32];
    logic [63:0] active_q [32];
    logic [63:0] active_d [32];

    logic        sck_s, cs_s, sdio_s, upd_s, cs_act, sck_rise, sck_fall, upd_rise;
    logic [2:0]  prof_s;
    logic [7:0]  instr;
    logic [6:0]  len, new_len;
    logic [63:0] rd_word;

    function automatic logic [6:0] reg_len(input logic [4:0] a);
        case (a)
            5'h08:                                  reg_len = 7'd16;
            5'h0B, 5'h0C, 5'h0E, 5'h0F, 5'h10, 5'h11,
            5'h12, 5'h13, 5'h14, 5'h15:             reg_len = 7'd64;
            default:                                reg_len = 7'd32;
        endcase
    endfunction

    function automatic logic reg_valid(input logic [4:0] a);
        reg_valid = (a <= 5'h16) && (a != 5'h05) && (a != 5'h06);
    endfunction

    function automatic logic [63:0] reg_reset(input int unsigned i);
        case (i)
            1:       reg_reset = 64'h0000_0000_0040_0820;
            2:       reg_reset = 64'h0000_0000_1F3F_4000;
            default: reg_reset = '0;
        endcase
    endfunction

    assign sck_s    = sync_q[SYNC_STAGES-1][0];
    assign cs_s     = sync_q[SYNC_STAGES-1][1];
    assign sdio_s   = sync_q[SYNC_STAGES-1][2];
    assign upd_s    = sync_q[SYNC_STAGES-1][3];
    assign prof_s   = sync_q[SYNC_STAGES-1][6:4];
    assign cs_act   = CS_ACTIVE_LOW ? ~cs_s : cs_s;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign upd_rise = upd_s & ~upd_prev_q;
    assign len      = reg_len(addr_q);

    always_comb begin
        sync_d[0] = {spi.profile, spi.io_update, spi.sdio_in, spi.cs, spi.sck};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        sck_prev_d     = sck_s;
        upd_prev_d     = upd_s;
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        addr_d         = addr_q;
        armed_d        = armed_q;
        sdio_out_d     = sdio_out_q;
        sdio_oe_d      = sdio_oe_q;
        frame_count_d  = frame_count_q;
        update_count_d = update_count_q;
        frame_error_d  = frame_error_q;
        shadow_d       = shadow_q;
        instr          = '0;
        new_len        = '0;
        rd_word        = '0;

        if (!cs_act) begin
            // A frame already running at reset release is skipped until cs drops first.
            armed_d    = 1'b1;
            state_d    = IDLE;
            sdio_oe_d  = 1'b0;
            sdio_out_d = 1'b0;
            case (state_q)
                INSTR:        if (bit_cnt_q != '0) frame_error_d = 1'b1;
                WDATA, RDATA: frame_error_d = 1'b1;
                DONE:         frame_count_d = frame_count_q + 16'd1;
                default:      ;
            endcase
        end else begin
            case (state_q)
                IDLE: if (armed_q) begin
                    state_d   = INSTR;
                    bit_cnt_d = '0;
                end
                INSTR: if (sck_rise) begin
                    shift_d   = {shift_q[62:0], sdio_s};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'd7) begin
                        instr     = shift_d[7:0];
                        addr_d    = instr[4:0];
                        bit_cnt_d = '0;
                        if (!reg_valid(instr[4:0])) frame_error_d = 1'b1;
                        if (instr[7]) begin
                            new_len    = reg_len(instr[4:0]);
                            rd_word    = reg_valid(instr[4:0]) ? active_q[instr[4:0]] : '0;
                            shift_d    = rd_word << (7'd64 - new_len);
                            sdio_out_d = shift_d[63];
                            sdio_oe_d  = 1'b1;
                            state_d    = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                WDATA: if (sck_rise) begin
                    shift_d   = {shift_q[62:0], sdio_s};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == len - 7'd1) begin
                        if (reg_valid(addr_q))
                            shadow_d[addr_q] = (len == 7'd64) ? shift_d
                                             : (shift_d & ((64'd1 << len) - 64'd1));
                        state_d = DONE;
                    end
                end
                RDATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 7'd1;
                        if (bit_cnt_q == len - 7'd1) begin
                            state_d   = DONE;
                            sdio_oe_d = 1'b0;
                        end
                    end else if (sck_fall && bit_cnt_q != '0) begin
                        // The MSB stays up through the fall that precedes the first data rise.
                        shift_d    = {shift_q[62:0], 1'b0};
                        sdio_out_d = shift_d[63];
                    end
                end
                default: ;
            endcase
        end

        active_d = active_q;
        if (upd_rise) begin
            active_d       = shadow_d;
            update_count_d = update_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                shadow_q[i] <= reg_reset(i);
                active_q[i] <= reg_reset(i);
            end
            sck_prev_q     <= 1'b0;
            upd_prev_q     <= 1'b0;
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            addr_q         <= '0;
            armed_q        <= 1'b0;
            sdio_out_q     <= 1'b0;
            sdio_oe_q      <= 1'b0;
            frame_count_q  <= '0;
            update_count_q <= '0;
            frame_error_q  <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            sck_prev_q     <= sck_prev_d;
            upd_prev_q     <= upd_prev_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            addr_q         <= addr_d;
            armed_q        <= armed_d;
            sdio_out_q     <= sdio_out_d;
            sdio_oe_q      <= sdio_oe_d;
            frame_count_q  <= frame_count_d;
            update_count_q <= update_count_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign spi.sdio_out    = sdio_out_q;
    assign spi.sdio_oe     = sdio_oe_q;
    assign cfr1_q          = active_q[0][31:0];
    assign cfr2_q          = active_q[1][31:0];
    assign cfr3_q          = active_q[2][31:0];
    assign ftw_q           = active_q[7][31:0];
    assign profile_word_q  = active_q[5'h0E + {2'b00, prof_s}];
    assign frame_count     = frame_count_q;
    assign update_count    = update_count_q;
    assign frame_error     = frame_error_q;
endmodule

// File: tb/tb_ad9910_spi_responder.sv
// Directed bench for ad9910_spi_responder: expected values go into a scoreboard
// queue as stimulus is driven and are popped against the DUT outputs.
module tb_ad9910_spi_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfr1_q, cfr2_q, cfr3_q, ftw_q;
    logic [63:0] profile_word_q;
    logic [15:0] frame_count, update_count;
    logic        frame_error;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];

    ad9910_spi_responder_if tif ();

    ad9910_spi_responder #(.CS_ACTIVE_LOW(1'b1), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi            (tif.slave),
        .cfr1_q         (cfr1_q),
        .cfr2_q         (cfr2_q),
        .cfr3_q         (cfr3_q),
        .ftw_q          (ftw_q),
        .profile_word_q (profile_word_q),
        .frame_count    (frame_count),
        .update_count   (update_count),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string t, input logic [63:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h required=%h", t, obs, e);
            end
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shifts n bits MSB first; samples sdio before each rise. Optional io_update on last rise.
    task automatic send_bits(input logic [63:0] data, input int n, input bit upd_last,
                             output logic [63:0] rdata, output bit oe_all);
        rdata  = '0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            tif.sdio_in = data[n-1-i];
            waitc(HALF);
            rdata  = {rdata[62:0], tif.sdio_out};
            oe_all = oe_all & tif.sdio_oe;
            if (upd_last && i == n - 1) tif.io_update = 1'b1;
            tif.sck = 1'b1;
            waitc(HALF);
            tif.sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] instr, input logic [63:0] data, input int nbits,
                         input bit release_cs, input bit upd_last,
                         output logic [63:0] rdata, output bit oe_instr_any,
                         output bit oe_data_all, output bit oe_after);
        logic [63:0] dummy;
        bit          oe_i;
        tif.cs = 1'b0;
        waitc(HALF);
        oe_instr_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tif.sdio_in = instr[7-i];
            waitc(HALF);
            oe_instr_any = oe_instr_any | tif.sdio_oe;
            tif.sck = 1'b1;
            waitc(HALF);
            tif.sck = 1'b0;
        end
        send_bits(data, nbits, upd_last, rdata, oe_i);
        oe_data_all = oe_i;
        waitc(HALF);
        oe_after = tif.sdio_oe;
        dummy = rdata;
        if (release_cs) tif.cs = 1'b1;
        waitc(2 * HALF);
        tif.io_update = 1'b0;
        waitc(2);
    endtask

    task automatic pulse_update();
        tif.io_update = 1'b1;
        waitc(HALF);
        tif.io_update = 1'b0;
        waitc(HALF);
    endtask

    initial begin
        logic [63:0] rd;
        bit          oe_i, oe_d, oe_a;

        tif.sck = 1'b0; tif.cs = 1'b1; tif.sdio_in = 1'b0;
        tif.io_update = 1'b0; tif.profile = 3'd0;
        waitc(5);
        reset = 1'b0;
        waitc(5);

        push("rst_cfr1", 64'h0);          pop_check({32'h0, cfr1_q});
        push("rst_cfr2", 64'h0040_0820);  pop_check({32'h0, cfr2_q});
        push("rst_cfr3", 64'h1F3F_4000);  pop_check({32'h0, cfr3_q});
        push("rst_ftw", 64'h0);           pop_check({32'h0, ftw_q});
        push("rst_fc", 64'h0);            pop_check({48'h0, frame_count});
        push("rst_uc", 64'h0);            pop_check({48'h0, update_count});
        push("rst_err", 64'h0);           pop_check({63'h0, frame_error});
        push("rst_oe", 64'h0);            pop_check({63'h0, tif.sdio_oe});

        // FTW write lands in shadow only until io_update
        frame(8'h07, 64'h1234_5678, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        push("t1_ftw_pre", 64'h0);        pop_check({32'h0, ftw_q});
        push("t1_fc", 64'd1);             pop_check({48'h0, frame_count});
        pulse_update();
        push("t1_ftw_post", 64'h1234_5678); pop_check({32'h0, ftw_q});
        push("t1_uc", 64'd1);             pop_check({48'h0, update_count});

        frame(8'h0E, 64'h3FFF_0000_1999_999A, 64, 1, 0, rd, oe_i, oe_d, oe_a);
        pulse_update();
        push("t2_prof0", 64'h3FFF_0000_1999_999A); pop_check(profile_word_q);
        tif.profile = 3'd1;
        waitc(4);
        push("t2_prof1", 64'h0);          pop_check(profile_word_q);
        tif.profile = 3'd0;
        waitc(4);

        frame(8'h81, 64'h0, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        push("t3_rdata", 64'h0040_0820);  pop_check(rd);
        push("t3_oe_instr", 64'h0);       pop_check({63'h0, oe_i});
        push("t3_oe_data", 64'h1);        pop_check({63'h0, oe_d});
        push("t3_oe_after", 64'h0);       pop_check({63'h0, oe_a});
        push("t3_fc", 64'd3);             pop_check({48'h0, frame_count});

        // Reads return the active value, not a pending shadow write
        frame(8'h07, 64'hAAAA_5555, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        frame(8'h87, 64'h0, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        push("rd_active", 64'h1234_5678); pop_check(rd);

        frame(8'h08, 64'h3FF, 10, 1, 0, rd, oe_i, oe_d, oe_a);
        push("t4_err", 64'h1);            pop_check({63'h0, frame_error});
        push("t4_fc", 64'd5);             pop_check({48'h0, frame_count});
        pulse_update();
        push("t4_ftw", 64'hAAAA_5555);    pop_check({32'h0, ftw_q});
        frame(8'h88, 64'h0, 16, 1, 0, rd, oe_i, oe_d, oe_a);
        push("t4_pow", 64'h0);            pop_check(rd);

        frame(8'h00, 64'h2, 32, 1, 1, rd, oe_i, oe_d, oe_a);
        push("t5_cfr1", 64'h2);           pop_check({32'h0, cfr1_q});
        push("t5_uc", 64'd4);             pop_check({48'h0, update_count});
        push("t5_fc", 64'd7);             pop_check({48'h0, frame_count});

        // Reset mid-frame; the still-open frame after release must be ignored
        frame(8'h0B, 64'hFFFF_FFFF_FFFF_FFFF, 20, 0, 0, rd, oe_i, oe_d, oe_a);
        reset = 1'b1;
        waitc(4);
        reset = 1'b0;
        waitc(4);
        push("t6_cfr1", 64'h0);           pop_check({32'h0, cfr1_q});
        push("t6_cfr2", 64'h0040_0820);   pop_check({32'h0, cfr2_q});
        push("t6_err", 64'h0);            pop_check({63'h0, frame_error});
        send_bits({24'h0, 8'h07, 32'hDEAD_BEEF}, 40, 0, rd, oe_d);
        waitc(HALF);
        tif.cs = 1'b1;
        waitc(2 * HALF);
        pulse_update();
        push("t6_ignored_ftw", 64'h0);    pop_check({32'h0, ftw_q});
        push("t6_ignored_fc", 64'h0);     pop_check({48'h0, frame_count});
        push("t6_ignored_err", 64'h0);    pop_check({63'h0, frame_error});
        frame(8'h07, 64'h0BAD_F00D, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        pulse_update();
        push("t6_ftw", 64'h0BAD_F00D);    pop_check({32'h0, ftw_q});
        push("t6_fc", 64'd1);             pop_check({48'h0, frame_count});

        frame(8'h17, 64'h5555_AAAA, 32, 1, 0, rd, oe_i, oe_d, oe_a);
        push("badaddr_err", 64'h1);       pop_check({63'h0, frame_error});
        push("badaddr_fc", 64'd2);        pop_check({48'h0, frame_count});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
